// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with ready/valid handshakes on both sides.
// Optional downstream-stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       Stall_Count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic                w_accept;
  logic                w_release;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  assign w_accept  = In_Valid & In_Ready;
  assign w_release = Out_Valid & Out_Ready;

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (Flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_next = S_ONE;
        S_ONE: begin
          if (w_accept && !w_release)      w_next = S_TWO;
          else if (!w_accept && w_release) w_next = S_EMPTY;
        end
        S_TWO:   if (w_release) w_next = S_ONE;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Ready is purely a function of registered state, so Out_Ready never reaches In_Ready.
  always_comb begin
    In_Ready  = (r_state != S_TWO);
    Out_Valid = (r_state != S_EMPTY);
    Out_Ctrl  = (r_state != S_EMPTY) ? r_main_ctrl : '0;
    Out_Data  = r_main_data;
  end

  // Flush suppresses every load so held payloads stay untouched, only marked invalid.
  always_comb begin
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (!Flush) begin
      w_load_main_in   = w_accept && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_release));
      w_load_skid      = w_accept && (r_state == S_ONE) && !w_release;
      w_load_main_skid = (r_state == S_TWO) && w_release;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= In_Ctrl;
        r_main_data <= In_Data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= In_Ctrl;
        r_skid_data <= In_Data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge Clock) begin
    if (Reset)
      r_stall_count <= '0;
    else if (Out_Valid && !Out_Ready && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign Stall_Count = r_stall_count;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then randomized traffic,
// checked against a capacity-2 FIFO reference model.
module tb_pipe_stage_reg;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] data;
  } entry_t;

  logic        Clock;
  logic        Reset;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  In_Ctrl;
  logic [31:0] In_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [7:0]  Out_Ctrl;
  logic [31:0] Out_Data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] Stall_Count;
`endif

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Ctrl   (In_Ctrl),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Ctrl  (Out_Ctrl),
    .Out_Data  (Out_Data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .Stall_Count (Stall_Count)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: exp_q holds the entries the stage should contain, oldest first.
  entry_t      exp_q[$];
  bit          pend;
  bit          kill;
  bit          kill_rst;
  bit          en;
  logic [31:0] last_head;
  longint unsigned stall_model;
  int unsigned n_cmp;
  int unsigned n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus; an entry the model says will be accepted is pushed now.
  task automatic drive(input bit rst, input bit fl, input bit iv,
                       input logic [7:0] c, input logic [31:0] d, input bit ordy);
    entry_t e;
    @(posedge Clock);
    #1;
    Reset     = rst;
    Flush     = fl;
    In_Valid  = iv;
    In_Ctrl   = c;
    In_Data   = d;
    Out_Ready = ordy;
    kill      = rst | fl;
    kill_rst  = rst;
    if (!rst && !fl && iv && (exp_q.size() < 2)) begin
      e.ctrl = c;
      e.data = d;
      exp_q.push_back(e);
      pend = 1'b1;
    end else begin
      pend = 1'b0;
    end
  endtask

  task automatic idle(input bit ordy, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, ordy);
  endtask

  // Monitor: compares the state left by the last edge, then retires what the next edge releases.
  always @(negedge Clock) begin
    int held;
    if (en) begin
      held = exp_q.size() - (pend ? 1 : 0);
      check("in_ready", {63'd0, In_Ready}, {63'd0, held < 2});
      check("out_valid", {63'd0, Out_Valid}, {63'd0, held > 0});
      if (held > 0) begin
        check("out_ctrl", {56'd0, Out_Ctrl}, {56'd0, exp_q[0].ctrl});
        check("out_data", {32'd0, Out_Data}, {32'd0, exp_q[0].data});
        last_head = exp_q[0].data;
      end else begin
        check("bubble_ctrl", {56'd0, Out_Ctrl}, 64'd0);
        check("bubble_data", {32'd0, Out_Data}, {32'd0, last_head});
      end
`ifdef PIPE_STAGE_PERF_EN
      check("stall_count", {32'd0, Stall_Count}, stall_model);
`endif
      if (kill_rst) begin
        stall_model = 0;
        last_head   = '0;
      end else if (held > 0 && !Out_Ready && stall_model < 64'hFFFF_FFFF) begin
        stall_model = stall_model + 1;
      end
      if (kill) exp_q.delete();
      else if (held > 0 && Out_Ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1; Flush = 1'b0; In_Valid = 1'b0; In_Ctrl = '0; In_Data = '0; Out_Ready = 1'b0;
    kill = 1'b1; kill_rst = 1'b1; pend = 1'b0;
    last_head = '0;
    stall_model = 0;
    en = 1'b1;

    // Single transfer with one-cycle latency
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 8'h05, 32'h0000_1234, 1'b1);
    idle(1'b1, 2);

    // Fill to TWO with downstream stalled, then drain in order
    drive(1'b0, 1'b0, 1'b1, 8'h01, 32'h11, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h02, 32'h22, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h03, 32'h99, 1'b0);
    idle(1'b1, 3);

    // Back-to-back stream
    for (int unsigned i = 1; i <= 8; i++) drive(1'b0, 1'b0, 1'b1, 8'(i), 32'(i), 1'b1);
    idle(1'b1, 2);

    // Flush from TWO with a same-cycle input
    drive(1'b0, 1'b0, 1'b1, 8'h33, 32'h33, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h44, 32'h44, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'h55, 32'h55, 1'b0);
    idle(1'b1, 3);

    // Stall accounting: ten stalled cycles, flush keeps the count, reset clears it
    drive(1'b0, 1'b0, 1'b1, 8'h66, 32'h66, 1'b0);
    idle(1'b0, 10);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1);
    idle(1'b1, 2);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1);
    idle(1'b1, 2);

    // Reset in TWO with a same-cycle input
    drive(1'b0, 1'b0, 1'b1, 8'h77, 32'h77, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h88, 32'h88, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h99, 32'h99, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'hAA, 32'hAA, 1'b1);
    idle(1'b1, 2);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 7,
            8'($urandom),
            $urandom,
            $urandom_range(0, 9) < 6);
    end
    idle(1'b1, 4);

    @(posedge Clock);
    #2;
    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the data payload (ALU result, store data, PC+4 and similar).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (MemRead, MemWrite, RegWrite, ByteSel and similar).
REQ-003 Port Clock  input  1  rising-edge clock for all state.
REQ-004 Port Reset  input  1  reset; synchronous, active-high; clock Clock.
REQ-005 Port Flush  input  1  discards every held entry at the next edge.
REQ-006 Port In_Valid  input  1  upstream presents an entry.
REQ-007 Port In_Ready  output  1  stage can accept an entry this cycle.
REQ-008 Port In_Ctrl  input  CTRL_W  upstream control payload.
REQ-009 Port In_Data  input  DATA_W  upstream data payload.
REQ-010 Port Out_Valid  output  1  stage presents an entry.
REQ-011 Port Out_Ready  input  1  downstream accepts this cycle.
REQ-012 Port Out_Ctrl  output  CTRL_W  control payload of head entry.
REQ-013 Port Out_Data  output  DATA_W  data payload of head entry.
REQ-014 Port Stall_Count  output  32  downstream-stall cycle count; present only when PIPE_STAGE_PERF_EN is defined.

Function
REQ-015 The stage SHALL hold up to two entries: a main register (drives outputs) and a skid register.
REQ-016 The state machine SHALL have states EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-017 Accept SHALL occur when In_Valid and In_Ready are both high; release SHALL occur when Out_Valid and Out_Ready are both high.
REQ-018 In_Ready SHALL be high in EMPTY and ONE, low in TWO, and SHALL depend only on registered state (no combinational path from Out_Ready).
REQ-019 Out_Valid SHALL be high exactly in states ONE and TWO.
REQ-020 Transitions: EMPTY+accept->ONE; ONE+accept-only->TWO; ONE+release-only->EMPTY; ONE+accept+release->ONE (main loads input); TWO+release->ONE (main loads skid); all other cases hold.
REQ-021 In ONE with accept and no release, the input SHALL be written to skid; main SHALL be unchanged.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N is on Out_* with Out_Valid high after edge N.
REQ-023 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped except by Flush or Reset.
REQ-024 When Out_Valid is low, Out_Ctrl SHALL be all zeros (bubble carries no side effects); Out_Data SHALL hold its last value.
REQ-025 Sustained In_Valid and Out_Ready high SHALL yield one entry per cycle throughput.
REQ-026 Flush high SHALL force EMPTY at the next edge, discarding held entries and any same-cycle accept; In_Ready MAY be high during Flush but the entry is lost.
REQ-027 Flush SHALL NOT alter Out_Data or skid contents beyond marking them invalid.

Reset
REQ-028 Reset SHALL take priority over Flush and all handshakes.
REQ-029 After Reset: state EMPTY, In_Ready 1, Out_Valid 0, Out_Ctrl 0, Out_Data 0, skid contents 0, Stall_Count 0.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; the first cycle after Reset deasserts SHALL accept normally.

Configuration
REQ-031 Macro PIPE_STAGE_PERF_EN defined: Stall_Count SHALL increment each cycle with Out_Valid high and Out_Ready low, saturate at 0xFFFFFFFF, clear only on Reset (not Flush).
REQ-032 Macro PIPE_STAGE_PERF_EN undefined: Stall_Count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset, then In_Valid=1, In_Data=0x0000_1234, In_Ctrl=0x05, Out_Ready=1 -> after one edge Out_Valid=1, Out_Data=0x0000_1234, Out_Ctrl=0x05.
REQ-034 Out_Ready=0, push A=0x11 then B=0x22 -> state TWO, In_Ready=0, Out_Data=0x11; raise Out_Ready two cycles -> 0x11 then 0x22 emitted, In_Ready=1.
REQ-035 Stream 0x1..0x8 with Out_Ready=1 throughout -> 8 outputs on 8 consecutive cycles, in order.
REQ-036 State TWO holding 0x33,0x44, Flush=1 with In_Valid=1, In_Data=0x55 -> next cycle Out_Valid=0, Out_Ctrl=0, 0x55 never emitted.
REQ-037 PERF_EN build: hold one entry with Out_Ready=0 for 10 cycles -> Stall_Count=10; Flush -> still 10; Reset -> 0.
REQ-038 Reset asserted in state TWO with In_Valid=1 -> next cycle Out_Valid=0, all outputs 0, In_Ready=1.
